// File: rtl/mlp_layer_ctrl_if.sv
// Control/address bundle between the MLP layer sequencer and its consumers.
// Ports: start/stall in towards the sequencer; busy, in_addr, weight_addr,
//        mac_en, reset_mu, write_neuron, out_neuron_addr, done out of it.
interface mlp_layer_ctrl_if #(
  parameter int IN_ADDR_W = 12,
  parameter int W_ADDR_W  = 16
) ();
  logic                 start;
  logic                 stall;
  logic                 busy;
  logic [IN_ADDR_W-1:0] in_addr;
  logic [W_ADDR_W-1:0]  weight_addr;
  logic                 mac_en;
  logic                 reset_mu;
  logic                 write_neuron;
  logic [11:0]          out_neuron_addr;
  logic                 done;

  // master: the sequencer itself
  modport master (
    input  start, stall,
    output busy, in_addr, weight_addr, mac_en, reset_mu,
           write_neuron, out_neuron_addr, done
  );

  // slave: whoever issues start/stall and consumes the addresses/strobes
  modport slave (
    output start, stall,
    input  busy, in_addr, weight_addr, mac_en, reset_mu,
           write_neuron, out_neuron_addr, done
  );
endinterface

// File: rtl/mlp_layer_ctrl.sv
// Sequencing FSM for one fully-connected MLP layer: clears the MAC, streams
// N_IN activation/weight address pairs per output neuron, then flags writeback.
// Ports: clk, reset (sync, active-high), bus (mlp_layer_ctrl_if.master).
module mlp_layer_ctrl #(
  parameter int N_IN      = 16,
  parameter int N_OUT     = 8,
  parameter int IN_ADDR_W = 12,
  parameter int W_ADDR_W  = 16,
  parameter int OUT_BASE  = 0
) (
  input logic              clk,
  input logic              reset,
  mlp_layer_ctrl_if.master bus
);

  localparam int OUT_IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, WRITE, DONE} state_t;

  state_t               state_q;
  logic [IN_ADDR_W-1:0] in_idx_q;
  logic [OUT_IDX_W-1:0] out_idx_q;
  logic [W_ADDR_W-1:0]  wptr_q;
  logic [W_ADDR_W-1:0]  wlast_q;   // last weight address issued, shown outside ACCUM
  logic [11:0]          out_addr_q;
  logic                 reset_mu_q;
  logic                 write_q;
  logic                 done_q;
  logic                 busy_q;

  logic in_last;
  logic out_last;

  assign in_last  = (in_idx_q == IN_ADDR_W'(N_IN - 1));
  assign out_last = (out_idx_q == OUT_IDX_W'(N_OUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      in_idx_q   <= '0;
      out_idx_q  <= '0;
      wptr_q     <= '0;
      wlast_q    <= '0;
      out_addr_q <= '0;
      reset_mu_q <= 1'b0;
      write_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // Strobes are registered against the state being entered, so each
      // one is high for exactly the cycle spent in its state.
      reset_mu_q <= 1'b0;
      write_q    <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= CLEAR;
            out_idx_q  <= '0;
            wptr_q     <= '0;
            reset_mu_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        CLEAR: begin
          state_q  <= ACCUM;
          in_idx_q <= '0;
        end
        ACCUM: begin
          if (!bus.stall) begin
            // Pointer runs continuously across neurons, giving row-major
            // [out][in] addressing without a multiplier.
            wptr_q  <= wptr_q + W_ADDR_W'(1);
            wlast_q <= wptr_q;
            if (in_last) begin
              state_q    <= WRITE;
              write_q    <= 1'b1;
              out_addr_q <= 12'(OUT_BASE) + 12'(out_idx_q);
            end else begin
              in_idx_q <= in_idx_q + IN_ADDR_W'(1);
            end
          end
        end
        WRITE: begin
          if (out_last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= CLEAR;
            out_idx_q  <= out_idx_q + OUT_IDX_W'(1);
            reset_mu_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy            = busy_q;
  assign bus.reset_mu        = reset_mu_q;
  assign bus.write_neuron    = write_q;
  assign bus.done            = done_q;
  assign bus.out_neuron_addr = out_addr_q;
  assign bus.in_addr         = in_idx_q;
  // While accumulating the live pointer is shown; elsewhere the last issued
  // address is held so the weight memory sees no spurious address change.
  assign bus.weight_addr     = (state_q == ACCUM) ? wptr_q : wlast_q;
  // mac_en is gated by stall in the same cycle: a stalled operand pair must
  // not be accumulated, and the counters hold so it is retried next cycle.
  assign bus.mac_en          = (state_q == ACCUM) && !bus.stall;

endmodule
